// File: rtl/canvas_pkg.sv
// canvas_pkg: shared constants, beat payload and scan FSM state for the
// canvas read-back path.
//   GRID_SIZE/NPIX/ADDR_W : canvas geometry and address width
//   PIX_ON/PIX_OFF        : activation values for set / clear cells
//   pix_beat_t            : one streamed pixel {data, x, y, last}
//   scan_state_t          : canvas_stream_reader FSM states
package canvas_pkg;

    localparam int unsigned GRID_SIZE = 28;
    localparam int unsigned NPIX      = GRID_SIZE * GRID_SIZE;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned XY_W      = 5;
    localparam int unsigned PIX_W     = 8;

    localparam logic [PIX_W-1:0] PIX_ON  = 8'd255;
    localparam logic [PIX_W-1:0] PIX_OFF = 8'd0;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic [XY_W-1:0]  x;
        logic [XY_W-1:0]  y;
        logic             last;
    } pix_beat_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    // True for the bottom-right cell, which carries the last flag.
    function automatic logic is_last_cell(input logic [XY_W-1:0] x, input logic [XY_W-1:0] y);
        return (x == XY_W'(GRID_SIZE - 1)) && (y == XY_W'(GRID_SIZE - 1));
    endfunction

endpackage

// File: rtl/pix_fifo2.sv
// pix_fifo2: 2-deep first-word-fall-through FIFO of pix_beat_t.
//   clk, reset : clock and synchronous active-high reset (flushes contents)
//   push, din  : write a beat; dropped if full with no simultaneous pop
//   pop        : remove the head; ignored when empty
//   dout       : current head (valid while count != 0)
//   count      : number of stored beats, 0..2
module pix_fifo2
    import canvas_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  pix_beat_t din,
    input  logic      pop,
    output pix_beat_t dout,
    output logic [1:0] count
);

    pix_beat_t  mem_q [2];
    pix_beat_t  mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    // Full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin : next_state
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = 2'(count_q + 2'(do_push) - 2'(do_pop));
    end

    always_ff @(posedge clk) begin : regs
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/canvas_stream_reader.sv
// canvas_stream_reader: scans the 28x28 1-bit canvas in raster order through
// its synchronous read port and streams each cell as an 8-bit activation.
//   CLOCK_50, reset     : clock, synchronous active-high reset
//   start               : 1-cycle scan request, ignored unless idle
//   rd_addr/rd_en       : canvas read port, rd_data returns one cycle later
//   pix_valid/pix_ready : stream handshake
//   pix_data/x/y/last   : current beat (FIFO head)
//   busy                : scan in progress (canvas writes frozen)
//   done                : 1-cycle pulse after the last beat is accepted
module canvas_stream_reader
    import canvas_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic              rd_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic [XY_W-1:0]   pix_x,
    output logic [XY_W-1:0]   pix_y,
    output logic              pix_last,
    output logic              busy,
    output logic              done
);

    scan_state_t       state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              infl_q, infl_d;
    logic [XY_W-1:0]   wr_x_q, wr_x_d;
    logic [XY_W-1:0]   wr_y_q, wr_y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    pix_beat_t  push_beat;
    pix_beat_t  head;
    logic [1:0] fifo_count;
    logic       push, pop;
    logic [2:0] occupancy;
    logic       credit_ok;

    // The read issued last cycle lands in the FIFO at this edge.
    assign push = infl_q;
    assign pop  = pix_valid && pix_ready;

    always_comb begin : beat_build
        push_beat.data = rd_data ? PIX_ON : PIX_OFF;
        push_beat.x    = wr_x_q;
        push_beat.y    = wr_y_q;
        push_beat.last = is_last_cell(wr_x_q, wr_y_q);
    end

    // A new read lands one edge later; after this cycle's pop and the
    // in-flight push there must still be a free slot for it.
    assign occupancy = 3'(fifo_count) + 3'(infl_q) - 3'(pop);
    assign credit_ok = (occupancy < 3'd2);

    always_comb begin : next_state
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_x_d   = wr_x_q;
        wr_y_d   = wr_y_q;
        rd_en    = 1'b0;

        // Beat coordinates advance per push; y saturates on the last row.
        if (push) begin
            if (wr_x_q == XY_W'(GRID_SIZE - 1)) begin
                wr_x_d = '0;
                if (wr_y_q != XY_W'(GRID_SIZE - 1)) begin
                    wr_y_d = wr_y_q + XY_W'(1);
                end
            end else begin
                wr_x_d = wr_x_q + XY_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SCAN;
                    rd_ptr_d = '0;
                    wr_x_d   = '0;
                    wr_y_d   = '0;
                end
            end
            ST_SCAN: begin
                if (credit_ok) begin
                    rd_en = 1'b1;
                    if (rd_ptr_q == ADDR_W'(NPIX - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head.last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        infl_d = rd_en;
        busy_d = (state_d == ST_SCAN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLOCK_50) begin : regs
        if (reset) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= '0;
            infl_q   <= 1'b0;
            wr_x_q   <= '0;
            wr_y_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            infl_q   <= infl_d;
            wr_x_q   <= wr_x_d;
            wr_y_q   <= wr_y_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    pix_fifo2 u_fifo (
        .clk   (CLOCK_50),
        .reset (reset),
        .push  (push),
        .din   (push_beat),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count)
    );

    assign rd_addr   = rd_ptr_q;
    assign pix_valid = (fifo_count != 2'd0);
    assign pix_data  = head.data;
    assign pix_x     = head.x;
    assign pix_y     = head.y;
    assign pix_last  = head.last;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
